// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reordering stage for a radix-2 DIT FFT output.
// Ping-pong frame buffers: one bank fills in bit-reversed order while the other
// drains in natural order through a single valid/ready output register.
module fft_bitrev_reorder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2_NFFT  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [LOG2_NFFT-1:0]  out_index,
  output logic                  out_last,
  output logic                  frame_err
);

  localparam int unsigned NFFT   = 1 << LOG2_NFFT;
  localparam int unsigned WORD_W = 2 * DATA_WIDTH;
  localparam logic [LOG2_NFFT-1:0] CNT_MAX = LOG2_NFFT'(NFFT - 1);

  // Frame storage: [bank][address], each word is {real, imag}; not reset
  logic [WORD_W-1:0] mem_q [2][NFFT];

  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [LOG2_NFFT-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LOG2_NFFT-1:0]  rd_cnt_q, rd_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_r_q, out_r_d;
  logic [DATA_WIDTH-1:0] out_i_q, out_i_d;
  logic [LOG2_NFFT-1:0]  out_index_q, out_index_d;
  logic                  out_last_q, out_last_d;
  logic                  frame_err_q, frame_err_d;

  logic                  wr_fire;
  logic                  wr_end;
  logic [LOG2_NFFT-1:0]  wr_addr;
  logic                  rd_load;
  logic                  rd_end;
  logic [WORD_W-1:0]     rd_word;

  // Next-state logic for write counter, bank flags, framing check and output register
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    frame_err_d = frame_err_q;

    in_ready = !full_q[wr_bank_q];
    wr_fire  = in_valid && in_ready;
    wr_end   = (wr_cnt_q == CNT_MAX);
    wr_addr  = {<<{wr_cnt_q}};
    rd_word  = mem_q[rd_bank_q][rd_cnt_q];
    rd_load  = full_q[rd_bank_q] && (!out_valid_q || out_ready);
    rd_end   = (rd_cnt_q == CNT_MAX);

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + LOG2_NFFT'(1);
      // Framing is judged purely by the counter; in_last never realigns it
      if (in_last != wr_end) frame_err_d = 1'b1;
      if (wr_end) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    if (rd_load) begin
      out_valid_d = 1'b1;
      out_r_d     = rd_word[WORD_W-1:DATA_WIDTH];
      out_i_d     = rd_word[DATA_WIDTH-1:0];
      out_index_d = rd_cnt_q;
      out_last_d  = rd_end;
      rd_cnt_d    = rd_cnt_q + LOG2_NFFT'(1);
      if (rd_end) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Scatter incoming samples to their bit-reversed address in the write bank
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_addr] <= {in_r, in_i};
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: scenario table plus hand-written corner sequences.
module tb_fft_bitrev_reorder;

  localparam int DW = 32;
  localparam int LN = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic [LN-1:0] out_index;
  logic          out_last;
  logic          frame_err;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2_NFFT(LN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_index(out_index), .out_last(out_last), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int stalls = 0;

  // lmode: 0 in_last at 31, 1 also at 20, 2 never, 3 also at 3
  typedef struct {
    int nf;
    int mode;
    int lmode;
    int fbase;
    bit exp_err;
    bit chk_cont;
  } scen_t;

  scen_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < LN; b++) if (((k >> b) & 1) != 0) r |= 1 << (LN - 1 - b);
    return r;
  endfunction

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Send frames in bit-reversed order; stops after maxs accepted samples
  task automatic drive(input int nf, input int lmode, input int fbase, input int maxs);
    int cnt = 0;
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < N; k++) begin
        int v;
        bit hs;
        int cyc;
        if (cnt >= maxs) break;
        v        = brev(k) + 256 * (fbase + f);
        in_valid = 1'b1;
        in_r     = 32'(v);
        in_i     = 32'(-v);
        case (lmode)
          1:       in_last = (k == 20) || (k == 31);
          2:       in_last = 1'b0;
          3:       in_last = (k == 3) || (k == 31);
          default: in_last = (k == 31);
        endcase
        cyc = 0;
        do begin
          @(negedge clk);
          hs = in_ready;
          if (!hs) stalls++;
          @(posedge clk); #1;
          cyc++;
        end while (!hs && cyc < 5000);
        if (!hs) begin
          total++;
          $display("FAIL drive_timeout: got no in_ready, expected in_ready within 5000 cycles");
          in_valid = 1'b0;
          return;
        end
        cnt++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Accept nf frames and check natural order, data, last flag and hold-under-stall
  task automatic collect(input int nf, input int mode, input int fbase, output int gaps);
    int got = 0, cyc = 0, f = 0, n = 0, held = 0;
    bit started = 0, holding = 0;
    gaps = 0;
    while (got < nf * N && cyc < 3000) begin
      @(posedge clk); #1;
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      cyc++;
      @(negedge clk);
      if (holding) check("hold_index", {32'b0, out_valid, out_index}, {32'b0, 1'b1, LN'(held)});
      holding = 0;
      if (out_valid && out_ready) begin
        int v;
        logic [DW-1:0] er, ei;
        v  = n + 256 * (fbase + f);
        er = 32'(v);
        ei = 32'(-v);
        check("out_index", 64'(out_index), 64'(n));
        check("out_data", {out_r, out_i}, {er, ei});
        check("out_last", 64'(out_last), 64'(n == N - 1));
        got++;
        n++;
        if (n == N) begin
          n = 0;
          f++;
        end
      end else if (out_valid) begin
        holding = 1;
        held    = int'(out_index);
      end else if (started) begin
        gaps++;
      end
      if (out_valid) started = 1;
    end
    if (got < nf * N) begin
      total++;
      $display("FAIL collect_timeout: got %0d samples, expected %0d", got, nf * N);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int gaps;
    bit found;
    logic prev_rdy;

    tbl[0] = '{1, 0, 0, 0, 1'b0, 1'b1};
    tbl[1] = '{3, 0, 0, 1, 1'b0, 1'b1};
    tbl[2] = '{2, 1, 0, 4, 1'b0, 1'b0};
    tbl[3] = '{1, 0, 1, 2, 1'b1, 1'b0};
    tbl[4] = '{1, 0, 2, 8, 1'b1, 1'b0};

    rst = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", {out_r, out_i}, 64'(0));
    check("rst_out_index", 64'(out_index), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;

    // Scenario table
    for (int s = 0; s < 5; s++) begin
      do_reset();
      stalls = 0;
      fork
        drive(tbl[s].nf, tbl[s].lmode, tbl[s].fbase, tbl[s].nf * N);
        collect(tbl[s].nf, tbl[s].mode, tbl[s].fbase, gaps);
      join
      check("frame_err", 64'(frame_err), 64'(tbl[s].exp_err));
      if (tbl[s].chk_cont) begin
        check("out_gaps", 64'(gaps), 64'(0));
        check("in_stalls", 64'(stalls), 64'(0));
      end
      if (tbl[s].exp_err) begin
        repeat (4) @(negedge clk);
        check("err_sticky", 64'(frame_err), 64'(1));
      end
    end

    // First output appears one cycle after the last input handshake
    do_reset();
    out_ready = 1'b1;
    drive(1, 0, 7, N);
    @(negedge clk);
    check("lat_not_yet", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("lat_valid", {31'b0, out_valid, 27'b0, out_index}, {31'b0, 1'b1, 32'b0});
    check("lat_data", 64'(out_r), 64'(7 * 256));

    // Two full banks under backpressure, then release
    do_reset();
    out_ready = 1'b0;
    drive(2, 0, 3, 2 * N);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_hold", {31'b0, out_valid, 27'b0, out_index}, {31'b0, 1'b1, 32'b0});
      check("bp_data", 64'(out_r), 64'(3 * 256));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    prev_rdy = in_ready;
    found = 0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clk);
      if (out_index == LN'(N - 1)) begin
        check("bp_release_ready", 64'(in_ready), 64'(1));
        check("bp_prev_ready", 64'(prev_rdy), 64'(0));
        found = 1;
      end
      prev_rdy = in_ready;
    end
    if (!found) begin
      total++;
      $display("FAIL bp_timeout: got no out_index 31, expected it within 64 cycles");
    end

    // Asynchronous reset in the middle of a frame
    do_reset();
    out_ready = 1'b0;
    drive(1, 0, 5, N);
    drive(1, 3, 6, 10);
    @(negedge clk);
    check("mr_pre_err", 64'(frame_err), 64'(1));
    check("mr_pre_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'(0));
    check("mr_out_data", {out_r, out_i}, 64'(0));
    check("mr_out_idx_last", {out_last, out_index}, 64'(0));
    check("mr_frame_err", 64'(frame_err), 64'(0));
    check("mr_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    fork
      drive(1, 0, 9, N);
      collect(1, 0, 9, gaps);
    join
    check("mr_after_err", 64'(frame_err), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
